bcd_time_counter: RTL

//   Parametrised BCD time-of-day counter (HH:MM:SS) for board clock designs.

---
 rtl/bcd_time_counter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - BCD HH:MM:SS time-of-day counter with prescaler, validated load and adjust
// Define ALARM_EN to add the HH:MM alarm ports and logic.
module bcd_time_counter #(
  parameter int TICK_DIV = 100_000_000,
  parameter int HOURS    = 24
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        run,
  input  logic        load,
  input  logic [23:0] set_time,
  input  logic        inc_min,
  input  logic        inc_hour,
`ifdef ALARM_EN
  input  logic        alarm_set,
  input  logic [15:0] alarm_time,
  input  logic        alarm_on,
  input  logic        alarm_ack,
  output logic        alarm_out,
`endif
  output logic [23:0] time_bcd,
  output logic        sec_pulse,
  output logic        day_wrap,
  output logic        load_err
);

  localparam int            DW        = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
  localparam logic [7:0]    HOUR_LAST = {4'((HOURS - 1) / 10), 4'((HOURS - 1) % 10)};

  // Hour pair is legal when both digits are decimal and the value is below HOURS.
  function automatic logic hour_ok(input logic [7:0] h);
    logic [7:0] bin;
    bin = 8'd10 * {4'd0, h[7:4]} + {4'd0, h[3:0]};
    return (h[7:4] <= 4'd9) && (h[3:0] <= 4'd9) && (bin < 8'(HOURS));
  endfunction

  function automatic logic [7:0] sexa_inc(input logic [7:0] v);
    if (v[3:0] != 4'd9)
      return {v[7:4], v[3:0] + 4'd1};
    else if (v[7:4] != 4'd5)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return 8'h00;
  endfunction

  function automatic logic [7:0] hour_inc(input logic [7:0] h);
    if (h == HOUR_LAST)
      return 8'h00;
    else if (h[3:0] == 4'd9)
      return {h[7:4] + 4'd1, 4'd0};
    else
      return {h[7:4], h[3:0] + 4'd1};
  endfunction

  logic [DW-1:0] div_cnt;
  logic [7:0]    hh, mm, ss;
  logic          tick, load_ok, load_take, adj_take, tick_take;
  logic          carry_s, carry_m, wrap;
  logic [23:0]   time_tick, time_adj;

  assign {hh, mm, ss} = time_bcd;

  always_comb begin
    load_ok   = hour_ok(set_time[23:16]) &&
                (set_time[15:12] <= 4'd5) && (set_time[11:8] <= 4'd9) &&
                (set_time[7:4]   <= 4'd5) && (set_time[3:0]  <= 4'd9);
    tick      = run && (div_cnt == DIV_LAST);
    load_take = load && load_ok;
    adj_take  = !load_take && (inc_hour || inc_min);
    // A tick that collides with a load or an adjust is lost, not deferred.
    tick_take = tick && !load_take && !adj_take;

    time_adj  = inc_hour ? {hour_inc(hh), mm, ss} : {hh, sexa_inc(mm), ss};

    carry_s   = (ss == 8'h59);
    carry_m   = carry_s && (mm == 8'h59);
    time_tick = {carry_m ? hour_inc(hh) : hh, carry_s ? sexa_inc(mm) : mm, sexa_inc(ss)};
    wrap      = carry_m && (hh == HOUR_LAST);
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      div_cnt   <= '0;
      time_bcd  <= '0;
      sec_pulse <= 1'b0;
      day_wrap  <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      load_err  <= load && !load_ok;
      sec_pulse <= tick_take;
      day_wrap  <= tick_take && wrap;

      if (load_take)
        div_cnt <= '0;
      else if (run)
        div_cnt <= tick ? '0 : div_cnt + 1'b1;

      if (load_take)
        time_bcd <= set_time;
      else if (adj_take)
        time_bcd <= time_adj;
      else if (tick_take)
        time_bcd <= time_tick;
    end
  end

`ifdef ALARM_EN
  logic [15:0] alarm_q;
  logic        alarm_ok;

  assign alarm_ok = hour_ok(alarm_time[15:8]) &&
                    (alarm_time[7:4] <= 4'd5) && (alarm_time[3:0] <= 4'd9);

  // Only a real one-second advance onto HH:MM:00 can fire the alarm.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      alarm_q   <= '0;
      alarm_out <= 1'b0;
    end else begin
      if (alarm_set && alarm_ok)
        alarm_q <= alarm_time;
      if (alarm_ack || !alarm_on)
        alarm_out <= 1'b0;
      else if (tick_take && (time_tick[7:0] == 8'h00) && (time_tick[23:8] == alarm_q))
        alarm_out <= 1'b1;
    end
  end
`endif

endmodule
